pd_debug_capture: RTL and testbench
===================================

# pd_debug_capture

Trigger-based capture sequencer for the pattern generator's 16-word debug RAM. It accepts a stream of 32-bit pattern-generator samples and writes them into the RAM's second (s2) write port as a circular buffer. When a trigger arrives, it captures a programmable number of post-trigger samples, then stops and flags completion. The CPU reads the frozen buffer through s1 and uses `trig_addr` and `wrapped` to order the words.

## Interface
Parameters:
- `ADDR_W`, 4, RAM address width; depth is 2^ADDR_W = 16 words.
- `DATA_W`, 32, sample and RAM word width.

Ports:
- `clk`  in  1  single clock for all logic (same clock as RAM port s2).
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  pulse; starts a capture.
- `abort`  in  1  pulse; returns the block to IDLE.
- `trigger`  in  1  capture trigger.
- `freeze`  in  1  level; while high, all state and counters hold.
- `post_count`  in  ADDR_W  number of samples to capture after the trigger sample; sampled on the trigger cycle.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  DATA_W  pattern-generator snapshot.
- `ram_address`  out  ADDR_W  RAM port s2 address.
- `ram_byteenable`  out  4  constant 4'hF.
- `ram_chipselect`  out  1  s2 chip select; equal to `ram_write`.
- `ram_write`  out  1  s2 write strobe.
- `ram_writedata`  out  DATA_W  s2 write data.
- `state`  out  2  current state: IDLE=0, ARMED=1, POST=2, DONE=3.
- `wr_ptr`  out  ADDR_W  next address to be written.
- `trig_addr`  out  ADDR_W  address of the trigger sample.
- `wrapped`  out  1  the buffer has wrapped since arm.
- `done`  out  1  level; capture complete.
- `irq`  out  1  one-cycle pulse on entry to DONE.

## Operation
- An accepted sample is `sample_valid & ~freeze` while in ARMED or POST. In IDLE and DONE, samples are dropped.
- Each accepted sample is written at `wr_ptr`, then `wr_ptr` increments modulo 16. When `wr_ptr` rolls over from 15 to 0, `wrapped` is set.
- IDLE → ARMED on `arm`. On this transition, `wr_ptr`, `wrapped`, `done` and `trig_addr` are cleared.
- ARMED → POST on `trigger`:
  - `trig_addr` latches the current `wr_ptr`.
  - The remaining-sample counter (ADDR_W+1 bits) loads `post_count`+1.
  - The trigger sample is the first sample accepted on or after the trigger cycle.
  - If a sample is accepted in the trigger cycle, it is the trigger sample and the counter loads `post_count` instead.
- In POST, each accepted sample decrements the counter. The accept that brings the counter to 0 moves the block to DONE and sets `done`.
- DONE → ARMED on `arm`, which clears `done`, `wrapped` and `wr_ptr`.
- `abort` moves any state to IDLE; `done`, `wrapped` and `trig_addr` are cleared.
- Priority: `reset` > `freeze` > `abort` > `arm` > `trigger`.
- `arm` is ignored in ARMED and POST. `trigger` is ignored in IDLE, POST and DONE, and while `freeze` is high.
- With `post_count`=15, exactly 16 post-trigger words fill the RAM. The trigger sample is never overwritten.

## Timing
- Write pipeline: a sample accepted in cycle N drives `ram_write`/`ram_chipselect`=1 in cycle N+1, with `ram_address` = the `wr_ptr` from cycle N and `ram_writedata` = the `sample_data` from cycle N.
  - The strobe is high for exactly one cycle per accepted sample.
  - Back-to-back accepts every cycle are supported.
- `wr_ptr`, `state`, `trig_addr` and `wrapped` update in cycle N+1.
- `irq` is high for one cycle: the cycle `state` first reads DONE. That is the same cycle as the final `ram_write`.
- Reset values: `state`=IDLE, and `wr_ptr`, `trig_addr`, `wrapped`, `done`, `irq`, `ram_write`, `ram_chipselect`, `ram_address` and `ram_writedata` are all 0. `ram_byteenable`=4'hF.
- `reset` asserted in cycle N+1 cancels the write pending from cycle N (no `ram_write` in N+1).
- An accept in cycle N followed by `abort` in cycle N+1 still completes the pipelined write in N+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Basic capture.** Reset, `arm`, then 5 back-to-back samples 0xA0..0xA4 → writes to addresses 0..4 on consecutive cycles, each one cycle after its accept; `ram_byteenable`=F; final `wr_ptr`=5, `wrapped`=0, `state`=1.
- **Wrap.** `arm`, then 20 samples 0x00..0x13 → addresses 0..15 then 0..3; `wrapped` rises the cycle after the 16th accept; final `wr_ptr`=4; RAM word 2 holds 0x12.
- **Trigger with concurrent sample.** `post_count`=3; `arm`; 6 samples, then `trigger` together with sample 0x106, then 5 more samples → `trig_addr`=6; writes at 6..9 only; `irq` high for one cycle with the write to 9; `done`=1, `state`=3; the last two samples produce no write.
- **Freeze.** In ARMED with `wr_ptr`=3, hold `freeze` for 4 cycles with `sample_valid` high and one `trigger` pulse → no writes, `wr_ptr`=3, `state` stays ARMED.
- **Full post window.** `post_count`=15; trigger at `wr_ptr`=9; 20 samples → 16 writes at addresses 9..15, 0..8; `done` set; `trig_addr`=9.
- **Abort and reset mid-capture.** In POST, `abort`+`arm` in the same cycle → IDLE, `done`=0. In a separate run, `reset` the cycle after an accept → no `ram_write` that cycle, and all outputs at their reset values.

Source files
------------

// File: rtl/pd_debug_capture.sv
// pd_debug_capture
// Trigger-based capture sequencer for the pattern generator's 16-word debug RAM.
// Accepted samples are written into RAM port s2 as a circular buffer. After a
// trigger, a programmable number of post-trigger samples is captured, and then
// the buffer is frozen and completion is flagged. All outputs come from flops.
module pd_debug_capture #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              abort,
   input  logic              trigger,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] post_count,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic [1:0]        state,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              wrapped,
   output logic              done,
   output logic              irq
);

   localparam int CNT_W = ADDR_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_POST  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic              wrapped_q, wrapped_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ram_write_q, ram_write_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_writedata_q, ram_writedata_d;
   logic              accept;

   // Sample acceptance: only while capturing and not frozen.
   always_comb begin
      accept = sample_valid & ~freeze & ((state_q == ST_ARMED) | (state_q == ST_POST));
   end

   // Next-state logic: write pipeline, pointer/wrap tracking and capture sequencer.
   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      trig_addr_d     = trig_addr_q;
      wrapped_d       = wrapped_q;
      done_d          = done_q;
      irq_d           = 1'b0;
      cnt_d           = cnt_q;
      ram_write_d     = 1'b0;
      ram_address_d   = ram_address_q;
      ram_writedata_d = ram_writedata_q;

      // An accepted sample is written at the current pointer one cycle later.
      if (accept) begin
         ram_write_d     = 1'b1;
         ram_address_d   = wr_ptr_q;
         ram_writedata_d = sample_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         if (wr_ptr_q == PTR_LAST) begin
            wrapped_d = 1'b1;
         end else begin
            wrapped_d = wrapped_q;
         end
      end else begin
         ram_write_d = 1'b0;
      end

      // Control events in priority order; freeze holds the whole sequencer.
      if (freeze) begin
         state_d = state_q;
      end else if (abort) begin
         state_d     = ST_IDLE;
         done_d      = 1'b0;
         wrapped_d   = 1'b0;
         trig_addr_d = PTR_ZERO;
      end else if (arm && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
         state_d   = ST_ARMED;
         wr_ptr_d  = PTR_ZERO;
         wrapped_d = 1'b0;
         done_d    = 1'b0;
         if (state_q == ST_IDLE) begin
            trig_addr_d = PTR_ZERO;
         end else begin
            trig_addr_d = trig_addr_q;
         end
      end else if (trigger && (state_q == ST_ARMED)) begin
         trig_addr_d = wr_ptr_q;
         if (accept) begin
            // The sample in this cycle is the trigger sample itself.
            if (post_count == PTR_ZERO) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               irq_d   = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_POST;
               cnt_d   = {1'b0, post_count};
            end
         end else begin
            state_d = ST_POST;
            cnt_d   = {1'b0, post_count} + CNT_ONE;
         end
      end else if ((state_q == ST_POST) && accept) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
         end else begin
            state_d = ST_POST;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         wr_ptr_q        <= PTR_ZERO;
         trig_addr_q     <= PTR_ZERO;
         wrapped_q       <= 1'b0;
         done_q          <= 1'b0;
         irq_q           <= 1'b0;
         cnt_q           <= CNT_ZERO;
         ram_write_q     <= 1'b0;
         ram_address_q   <= PTR_ZERO;
         ram_writedata_q <= {DATA_W{1'b0}};
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         trig_addr_q     <= trig_addr_d;
         wrapped_q       <= wrapped_d;
         done_q          <= done_d;
         irq_q           <= irq_d;
         cnt_q           <= cnt_d;
         ram_write_q     <= ram_write_d;
         ram_address_q   <= ram_address_d;
         ram_writedata_q <= ram_writedata_d;
      end
   end

   assign ram_byteenable = 4'hF;
   assign ram_chipselect = ram_write_q;
   assign ram_write      = ram_write_q;
   assign ram_address    = ram_address_q;
   assign ram_writedata  = ram_writedata_q;
   assign state          = state_q;
   assign wr_ptr         = wr_ptr_q;
   assign trig_addr      = trig_addr_q;
   assign wrapped        = wrapped_q;
   assign done           = done_q;
   assign irq            = irq_q;

endmodule

// File: tb/tb_pd_debug_capture.sv
// tb_pd_debug_capture
// Directed stimulus with a write scoreboard: expected RAM writes are queued as
// stimulus is issued and a monitor pops and compares each observed write.
module tb_pd_debug_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        arm, abort, trigger, freeze;
   logic [3:0]  post_count;
   logic        sample_valid;
   logic [31:0] sample_data;
   logic [3:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write;
   logic [31:0] ram_writedata;
   logic [1:0]  state;
   logic [3:0]  wr_ptr, trig_addr;
   logic        wrapped, done, irq;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
      logic        irq;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [16];
   int          n_cmp = 0;
   int          n_bad = 0;

   pd_debug_capture #(.ADDR_W(4), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
      .freeze(freeze), .post_count(post_count), .sample_valid(sample_valid),
      .sample_data(sample_data), .ram_address(ram_address),
      .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_writedata(ram_writedata), .state(state),
      .wr_ptr(wr_ptr), .trig_addr(trig_addr), .wrapped(wrapped), .done(done),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] d, input logic i);
      exp_t e;
      e.a = a; e.d = d; e.irq = i;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; returns 1 time unit after the edge.
   task automatic step(input logic v, input logic [31:0] d, input logic trg,
                       input logic frz, input logic ab, input logic ar, input logic rst);
      sample_valid = v; sample_data = d; trigger = trg; freeze = frz;
      abort = ab; arm = ar; reset = rst;
      @(posedge clk);
      #1;
      sample_valid = 1'b0; sample_data = 32'h0; trigger = 1'b0; freeze = 1'b0;
      abort = 1'b0; arm = 1'b0; reset = 1'b0;
   endtask

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (ram_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_address, ram_writedata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {28'h0, ram_address}, {28'h0, e.a});
            chk("wr_data", ram_writedata, e.d);
            chk("wr_irq", {31'h0, irq}, {31'h0, e.irq});
            chk("wr_cs", {31'h0, ram_chipselect}, 32'h1);
            mem[ram_address] = ram_writedata;
         end
      end else if ((ram_chipselect !== 1'b0) || (irq !== 1'b0)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_strobe: cs %0b irq %0b with no write, required 0 0", ram_chipselect, irq);
      end
   end

   initial begin
      reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; freeze = 1'b0;
      post_count = 4'd0; sample_valid = 1'b0; sample_data = 32'h0;
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset values
      chk("rst_state", {30'h0, state}, 32'd0);
      chk("rst_wr_ptr", {28'h0, wr_ptr}, 32'd0);
      chk("rst_trig_addr", {28'h0, trig_addr}, 32'd0);
      chk("rst_flags", {28'h0, wrapped, done, irq, ram_write}, 32'd0);
      chk("rst_addr_data", ram_writedata | {28'h0, ram_address}, 32'd0);
      chk("rst_byteen", {28'h0, ram_byteenable}, 32'hF);

      // Basic capture: 5 samples to addresses 0..4
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("arm_state", {30'h0, state}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         push(4'(i), 32'hA0 + 32'(i), 1'b0);
         step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("basic_wr_ptr", {28'h0, wr_ptr}, 32'd5);
      chk("basic_wrapped", {31'h0, wrapped}, 32'd0);
      chk("basic_state", {30'h0, state}, 32'd1);
      chk("basic_byteen", {28'h0, ram_byteenable}, 32'hF);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Wrap: 20 samples, addresses 0..15 then 0..3
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_idle", {30'h0, state}, 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rearm_wr_ptr", {28'h0, wr_ptr}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         push(4'(i % 16), 32'(i), 1'b0);
         step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 14) chk("wrap_before", {31'h0, wrapped}, 32'd0);
         if (i == 15) chk("wrap_after16", {31'h0, wrapped}, 32'd1);
      end
      chk("wrap_wr_ptr", {28'h0, wr_ptr}, 32'd4);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wrap_word2", mem[2], 32'h12);

      // Trigger with concurrent sample, post_count=3
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      post_count = 4'd3;
      for (int i = 0; i < 6; i++) begin
         push(4'(i), 32'h100 + 32'(i), 1'b0);
         step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      push(4'd6, 32'h106, 1'b0);
      step(1'b1, 32'h106, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("trig_addr6", {28'h0, trig_addr}, 32'd6);
      chk("trig_post", {30'h0, state}, 32'd2);
      for (int i = 0; i < 5; i++) begin
         if (i < 3) push(4'(7 + i), 32'h107 + 32'(i), (i == 2));
         step(1'b1, 32'h107 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 2) begin
            chk("trig_done_state", {30'h0, state}, 32'd3);
            chk("trig_done", {31'h0, done}, 32'd1);
            chk("trig_irq", {31'h0, irq}, 32'd1);
         end
      end
      chk("trig_hold_state", {30'h0, state}, 32'd3);
      chk("trig_hold_ptr", {28'h0, wr_ptr}, 32'd10);
      chk("trig_irq_pulse", {31'h0, irq}, 32'd0);

      // Freeze: ARMED at wr_ptr=3, four frozen cycles with samples and a trigger
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("done_rearm", {28'h0, done, wrapped, state}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         push(4'(i), 32'h150 + 32'(i), 1'b0);
         step(1'b1, 32'h150 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'hDEAD, (k == 1), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("frz_wr_ptr", {28'h0, wr_ptr}, 32'd3);
      chk("frz_state", {30'h0, state}, 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("frz_no_trig", {30'h0, state}, 32'd1);

      // Full post window: trigger at wr_ptr=9, post_count=15
      for (int i = 0; i < 6; i++) begin
         push(4'(3 + i), 32'h200 + 32'(i), 1'b0);
         step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      post_count = 4'd15;
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_trig_addr", {28'h0, trig_addr}, 32'd9);
      chk("full_post", {30'h0, state}, 32'd2);
      for (int i = 0; i < 20; i++) begin
         if (i < 16) push(4'((9 + i) % 16), 32'h300 + 32'(i), (i == 15));
         step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 14) chk("full_not_yet", {31'h0, done}, 32'd0);
      end
      chk("full_done", {31'h0, done}, 32'd1);
      chk("full_state", {30'h0, state}, 32'd3);
      chk("full_trig_keep", {28'h0, trig_addr}, 32'd9);
      chk("full_wr_ptr", {28'h0, wr_ptr}, 32'd9);

      // Abort together with arm while in POST; pending write still completes
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      post_count = 4'd2;
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ab_post", {30'h0, state}, 32'd2);
      push(4'd0, 32'h400, 1'b0);
      step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("ab_state", {30'h0, state}, 32'd0);
      chk("ab_flags", {30'h0, done, wrapped}, 32'd0);
      chk("ab_trig_addr", {28'h0, trig_addr}, 32'd0);

      // Reset on the edge that would register an accepted sample: no write
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rs_armed", {30'h0, state}, 32'd1);
      step(1'b1, 32'h5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rs_write", {30'h0, ram_write, ram_chipselect}, 32'd0);
      chk("rs_state_ptr", {26'h0, state, wr_ptr}, 32'd0);
      chk("rs_addr_data", ram_writedata | {28'h0, ram_address}, 32'd0);
      chk("rs_flags", {28'h0, trig_addr} | {29'h0, wrapped, done, irq}, 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
